// File: rtl/unidade_controle_param_pkg.sv
// Shared definitions for the memory-game control unit: state codes and timer sizing.
package unidade_controle_pkg;

    typedef enum logic [4:0] {
        ST_INICIAL         = 5'h00,
        ST_PREPARA         = 5'h01,
        ST_INICIO_RODADA   = 5'h02,
        ST_MOSTRA          = 5'h03,
        ST_APAGA           = 5'h04,
        ST_INICIO_JOGADA   = 5'h05,
        ST_ESPERA_JOGADA   = 5'h06,
        ST_REGISTRA        = 5'h07,
        ST_COMPARA         = 5'h08,
        ST_FEEDBACK        = 5'h09,
        ST_ESPERA_GRAVACAO = 5'h0A,
        ST_GRAVA           = 5'h0B,
        ST_MOSTRA_GRAVACAO = 5'h0C,
        ST_PERDE_VIDA      = 5'h0D,
        ST_GANHOU          = 5'h0E,
        ST_PERDEU          = 5'h0F,
        ST_TIMEOUT         = 5'h10
    } estado_t;

    // Bits needed to hold (longest interval - 1); never narrower than one bit.
    function automatic int timer_w(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (m < 2) return 1;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/unidade_controle_param_contador_limite.sv
// Up-counter with synchronous clear/enable and an equality flag against a moving limit.
module contador_limite #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         i_zera,
    input  logic         i_conta,
    input  logic [W-1:0] i_limite,
    output logic         o_fim
);

    logic [W-1:0] r_valor;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_valor <= '0;
        end else if (i_zera) begin
            r_valor <= '0;
        end else if (i_conta) begin
            r_valor <= r_valor + W'(1);
        end
    end

    assign o_fim = (r_valor == i_limite);

endmodule

// File: rtl/unidade_controle_param.sv
// Memory-game control unit: sequencing FSM plus address, round, lives and timer counters.
//
// state              | meaning
// inicial (00)       | idle, wait for iniciar
// prepara (01)       | latch round limit and speed, reset counters
// inicio_rodada (02) | dark gap before showing the sequence
// mostra (03)        | memory element lit
// apaga (04)         | dark gap between shown elements
// inicio_jogada (05) | rewind address for the player
// espera_jogada (06) | waiting for a move, timed
// registra (07)      | load move register
// compara (08)       | latch compare result
// feedback (09)      | player move lit, then branch
// espera_grav. (0A)  | waiting for an appended element, timed
// grava (0B)         | write appended element
// mostra_grav. (0C)  | appended element lit
// perde_vida (0D)    | spend a life
// ganhou/perdeu/timeout (0E/0F/10) | terminal, wait for iniciar
module unidade_controle_param
    import unidade_controle_pkg::*;
#(
    parameter int ADDR_W      = 4,
    parameter int SHOW_CYC    = 500,
    parameter int GAP_CYC     = 250,
    parameter int TIMEOUT_CYC = 5000,
    parameter int LIVES       = 3,
    parameter int LIVES_W     = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              iniciar,
    input  logic              jogada_feita,
    input  logic              jogada_correta,
    input  logic              modo_grava,
    input  logic              nivel_tempo,
    input  logic [ADDR_W-1:0] limite_rodadas,
    output logic [ADDR_W-1:0] endereco,
    output logic [ADDR_W-1:0] rodada,
    output logic              registraR,
    output logic              gravaM,
    output logic              ativa_leds_mem,
    output logic              ativa_leds_jog,
    output logic              vez_jogador,
    output logic              nova_jogada,
    output logic              ganhou,
    output logic              perdeu,
    output logic              pronto,
    output logic              timeout,
    output logic [LIVES_W-1:0] vidas,
    output logic [4:0]        db_estado
);

    localparam int TW = timer_w(SHOW_CYC, GAP_CYC, TIMEOUT_CYC);
    localparam logic [TW-1:0] L_SHOW    = TW'(SHOW_CYC - 1);
    localparam logic [TW-1:0] L_GAP     = TW'(GAP_CYC - 1);
    localparam logic [TW-1:0] L_TO_FULL = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] L_TO_HALF = TW'(TIMEOUT_CYC / 2 - 1);
    localparam logic [ADDR_W-1:0]  UM_A = ADDR_W'(1);
    localparam logic [LIVES_W-1:0] UM_V = LIVES_W'(1);

    estado_t r_estado;
    estado_t w_prox;

    logic [ADDR_W-1:0]  r_endereco;
    logic [ADDR_W-1:0]  r_rodada;
    logic [ADDR_W-1:0]  r_limite;
    logic [LIVES_W-1:0] r_vidas;
    logic               r_nivel;
    logic               r_ok;
    logic               r_ultimo;
    logic               r_timeout_pend;

    logic          w_fim;
    logic          w_conta;
    logic          w_zera;
    logic [TW-1:0] w_lim;

    // Per-state interval; the timer restarts on every state change.
    always_comb begin
        w_lim   = '0;
        w_conta = 1'b0;
        case (r_estado)
            ST_MOSTRA, ST_FEEDBACK, ST_MOSTRA_GRAVACAO: begin
                w_lim   = L_SHOW;
                w_conta = 1'b1;
            end
            ST_INICIO_RODADA, ST_APAGA: begin
                w_lim   = L_GAP;
                w_conta = 1'b1;
            end
            ST_ESPERA_JOGADA, ST_ESPERA_GRAVACAO: begin
                w_lim   = r_nivel ? L_TO_HALF : L_TO_FULL;
                w_conta = 1'b1;
            end
            default: begin
                w_lim   = '0;
                w_conta = 1'b0;
            end
        endcase
    end

    assign w_zera = (w_prox != r_estado);

    contador_limite #(.W(TW)) u_timer (
        .clock    (clock),
        .reset_n  (reset_n),
        .i_zera   (w_zera),
        .i_conta  (w_conta),
        .i_limite (w_lim),
        .o_fim    (w_fim)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_estado <= ST_INICIAL;
        end else begin
            r_estado <= w_prox;
        end
    end

    always_comb begin
        w_prox = r_estado;
        case (r_estado)
            ST_INICIAL:       if (iniciar) w_prox = ST_PREPARA;
            ST_PREPARA:       w_prox = ST_INICIO_RODADA;
            ST_INICIO_RODADA: if (w_fim) w_prox = ST_MOSTRA;
            ST_MOSTRA: begin
                if (w_fim) w_prox = (r_endereco == r_rodada) ? ST_INICIO_JOGADA : ST_APAGA;
            end
            ST_APAGA:         if (w_fim) w_prox = ST_MOSTRA;
            ST_INICIO_JOGADA: w_prox = ST_ESPERA_JOGADA;
            ST_ESPERA_JOGADA: begin
                if (w_fim)             w_prox = ST_PERDE_VIDA;
                else if (jogada_feita) w_prox = ST_REGISTRA;
            end
            ST_REGISTRA:      w_prox = ST_COMPARA;
            ST_COMPARA:       w_prox = ST_FEEDBACK;
            ST_FEEDBACK: begin
                if (w_fim) begin
                    if (!r_ok)                     w_prox = ST_PERDE_VIDA;
                    else if (!r_ultimo)            w_prox = ST_ESPERA_JOGADA;
                    else if (r_rodada == r_limite) w_prox = ST_GANHOU;
                    else if (modo_grava)           w_prox = ST_ESPERA_GRAVACAO;
                    else                           w_prox = ST_INICIO_RODADA;
                end
            end
            ST_ESPERA_GRAVACAO: begin
                if (w_fim)             w_prox = ST_PERDE_VIDA;
                else if (jogada_feita) w_prox = ST_GRAVA;
            end
            ST_GRAVA:           w_prox = ST_MOSTRA_GRAVACAO;
            ST_MOSTRA_GRAVACAO: if (w_fim) w_prox = ST_INICIO_JOGADA;
            ST_PERDE_VIDA: begin
                if (r_vidas == UM_V) w_prox = r_timeout_pend ? ST_TIMEOUT : ST_PERDEU;
                else                 w_prox = ST_INICIO_RODADA;
            end
            ST_GANHOU, ST_PERDEU, ST_TIMEOUT: if (iniciar) w_prox = ST_PREPARA;
            default:          w_prox = ST_INICIAL;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_endereco     <= '0;
            r_rodada       <= '0;
            r_limite       <= '0;
            r_vidas        <= LIVES_W'(LIVES);
            r_nivel        <= 1'b0;
            r_ok           <= 1'b0;
            r_ultimo       <= 1'b0;
            r_timeout_pend <= 1'b0;
        end else begin
            case (r_estado)
                ST_PREPARA: begin
                    r_limite       <= limite_rodadas;
                    r_nivel        <= nivel_tempo;
                    r_rodada       <= '0;
                    r_endereco     <= '0;
                    r_vidas        <= LIVES_W'(LIVES);
                    r_timeout_pend <= 1'b0;
                end
                ST_INICIO_RODADA, ST_INICIO_JOGADA: r_endereco <= '0;
                ST_APAGA: if (w_fim) r_endereco <= r_endereco + UM_A;
                ST_COMPARA: begin
                    r_ok     <= jogada_correta;
                    r_ultimo <= (r_endereco == r_rodada);
                end
                ST_FEEDBACK: begin
                    if (w_fim && r_ok) begin
                        if (!r_ultimo)                 r_endereco <= r_endereco + UM_A;
                        else if (r_rodada == r_limite) r_rodada   <= r_rodada;
                        else if (modo_grava)           r_endereco <= r_rodada + UM_A;
                        else                           r_rodada   <= r_rodada + UM_A;
                    end
                end
                ST_ESPERA_JOGADA, ST_ESPERA_GRAVACAO: if (w_fim) r_timeout_pend <= 1'b1;
                ST_GRAVA: r_rodada <= r_rodada + UM_A;
                ST_PERDE_VIDA: begin
                    r_vidas <= r_vidas - UM_V;
                    if (r_vidas != UM_V) r_timeout_pend <= 1'b0;
                end
                default: r_ok <= r_ok;
            endcase
        end
    end

    always_comb begin
        registraR      = 1'b0;
        gravaM         = 1'b0;
        ativa_leds_mem = 1'b0;
        ativa_leds_jog = 1'b0;
        vez_jogador    = 1'b0;
        nova_jogada    = 1'b0;
        ganhou         = 1'b0;
        perdeu         = 1'b0;
        pronto         = 1'b0;
        timeout        = 1'b0;
        case (r_estado)
            ST_MOSTRA, ST_MOSTRA_GRAVACAO: ativa_leds_mem = 1'b1;
            ST_FEEDBACK:        ativa_leds_jog = 1'b1;
            ST_ESPERA_JOGADA:   vez_jogador    = 1'b1;
            ST_ESPERA_GRAVACAO: nova_jogada    = 1'b1;
            ST_REGISTRA:        registraR      = 1'b1;
            ST_GRAVA: begin
                registraR = 1'b1;
                gravaM    = 1'b1;
            end
            ST_GANHOU: begin
                ganhou = 1'b1;
                pronto = 1'b1;
            end
            ST_PERDEU: begin
                perdeu = 1'b1;
                pronto = 1'b1;
            end
            ST_TIMEOUT: begin
                perdeu  = 1'b1;
                timeout = 1'b1;
                pronto  = 1'b1;
            end
            default: registraR = 1'b0;
        endcase
    end

    assign endereco  = r_endereco;
    assign rodada    = r_rodada;
    assign vidas     = r_vidas;
    assign db_estado = r_estado;

endmodule

// File: tb/tb_unidade_controle_param.sv
// Directed bench for unidade_controle_param with short show/gap/timeout intervals.
module tb_unidade_controle_param;

    localparam int SHOW = 3;
    localparam int GAP  = 2;
    localparam int TOUT = 20;

    logic       clock;
    logic       reset_n;
    logic       iniciar;
    logic       jogada_feita;
    logic       jogada_correta;
    logic       modo_grava;
    logic       nivel_tempo;
    logic [3:0] limite_rodadas;
    logic [3:0] endereco;
    logic [3:0] rodada;
    logic       registraR, gravaM, ativa_leds_mem, ativa_leds_jog;
    logic       vez_jogador, nova_jogada, ganhou, perdeu, pronto, timeout;
    logic [1:0] vidas;
    logic [4:0] db_estado;

    int n_assert = 0;
    int n_fail   = 0;

    unidade_controle_param #(
        .ADDR_W(4), .SHOW_CYC(SHOW), .GAP_CYC(GAP), .TIMEOUT_CYC(TOUT),
        .LIVES(3), .LIVES_W(2)
    ) dut (
        .clock(clock), .reset_n(reset_n), .iniciar(iniciar),
        .jogada_feita(jogada_feita), .jogada_correta(jogada_correta),
        .modo_grava(modo_grava), .nivel_tempo(nivel_tempo),
        .limite_rodadas(limite_rodadas), .endereco(endereco), .rodada(rodada),
        .registraR(registraR), .gravaM(gravaM), .ativa_leds_mem(ativa_leds_mem),
        .ativa_leds_jog(ativa_leds_jog), .vez_jogador(vez_jogador),
        .nova_jogada(nova_jogada), .ganhou(ganhou), .perdeu(perdeu),
        .pronto(pronto), .timeout(timeout), .vidas(vidas), .db_estado(db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input logic [4:0] st, input string tag);
        int c = 0;
        while (db_estado !== st && c < 500) begin
            tick();
            c++;
        end
        chk(tag, db_estado, st);
    endtask

    // Follows a display phase up to inicio_jogada, checking the address of each lit element.
    task automatic observe_show(input int n);
        int k = 0;
        int cyc = 0;
        int lit = 0;
        logic [4:0] prev = 5'h1f;
        while (db_estado !== 5'h05 && cyc < 300) begin
            if (db_estado === 5'h03) begin
                lit++;
                if (prev !== 5'h03) begin
                    chk("show_addr", endereco, k);
                    k++;
                end
            end
            prev = db_estado;
            tick();
            cyc++;
        end
        chk("show_count", k, n);
        chk("show_cycles", lit, n * SHOW);
        chk("show_end_state", db_estado, 5'h05);
    endtask

    // Plays one move; returns while the feedback LEDs are lit.
    task automatic do_move(input logic ok, input int addr);
        wait_state(5'h06, "move_wait");
        chk("move_vez", vez_jogador, 1'b1);
        chk("move_addr", endereco, addr);
        jogada_correta = ok;
        jogada_feita   = 1'b1;
        tick();
        jogada_feita   = 1'b0;
        chk("move_registra", {db_estado, registraR}, {5'h07, 1'b1});
        tick();
        chk("move_compara", db_estado, 5'h08);
        tick();
        chk("move_feedback", {db_estado, ativa_leds_jog}, {5'h09, 1'b1});
    endtask

    initial begin
        int gm, ms, mg, c;
        reset_n        = 1'b0;
        iniciar        = 1'b0;
        jogada_feita   = 1'b0;
        jogada_correta = 1'b0;
        modo_grava     = 1'b0;
        nivel_tempo    = 1'b0;
        limite_rodadas = 4'd2;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        tick();

        chk("rst_estado", db_estado, 5'h00);
        chk("rst_vidas", vidas, 2'd3);
        chk("rst_addr_round", {endereco, rodada}, 8'h00);
        chk("rst_flags", {ganhou, perdeu, pronto, timeout, vez_jogador, nova_jogada}, 6'b0);
        chk("rst_leds", {ativa_leds_mem, ativa_leds_jog, registraR, gravaM}, 4'b0);

        // Game 1: three rounds, all correct; mid-game limit change must be ignored.
        iniciar = 1'b1;
        tick();
        chk("g1_prepara", db_estado, 5'h01);
        iniciar = 1'b0;
        tick();
        chk("g1_inicio_rodada", db_estado, 5'h02);
        limite_rodadas = 4'd0;
        for (int r = 0; r < 3; r++) begin
            observe_show(r + 1);
            for (int i = 0; i <= r; i++) do_move(1'b1, i);
        end
        wait_state(5'h0E, "g1_ganhou_state");
        chk("g1_result", {ganhou, pronto, perdeu, timeout}, 4'b1100);
        chk("g1_vidas_round", {vidas, rodada}, {2'd3, 4'd2});

        // Game 2: wrong move in round 1, replay, then win.
        limite_rodadas = 4'd2;
        iniciar = 1'b1;
        tick();
        chk("g2_prepara", {db_estado, ganhou, pronto}, {5'h01, 2'b00});
        iniciar = 1'b0;
        observe_show(1);
        do_move(1'b1, 0);
        observe_show(2);
        do_move(1'b1, 0);
        do_move(1'b0, 1);
        wait_state(5'h0D, "g2_perde_vida");
        wait_state(5'h02, "g2_replay");
        chk("g2_after_error", {vidas, rodada}, {2'd2, 4'd1});
        observe_show(2);
        do_move(1'b1, 0);
        do_move(1'b1, 1);
        observe_show(3);
        for (int i = 0; i < 3; i++) do_move(1'b1, i);
        wait_state(5'h0E, "g2_ganhou_state");
        chk("g2_vidas_final", vidas, 2'd2);

        // Game 3: three wrong moves.
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        for (int it = 0; it < 3; it++) begin
            observe_show(1);
            do_move(1'b0, 0);
            if (it < 2) begin
                wait_state(5'h02, "g3_replay");
                chk("g3_vidas", vidas, 2 - it);
            end
        end
        wait_state(5'h0F, "g3_perdeu_state");
        chk("g3_result", {perdeu, timeout, pronto, ganhou}, 4'b1010);
        chk("g3_vidas_zero", vidas, 2'd0);
        iniciar = 1'b1;
        tick();
        chk("g3_restart", db_estado, 5'h01);
        iniciar = 1'b0;
        tick();
        chk("g3_restart_vidas", {db_estado, vidas}, {5'h02, 2'd3});

        // Game 4: three timeouts; first one races a same-cycle move.
        for (int it = 0; it < 3; it++) begin
            observe_show(1);
            tick();
            chk("to_entry", db_estado, 5'h06);
            repeat (TOUT - 1) tick();
            chk("to_last_cycle", {db_estado, vez_jogador}, {5'h06, 1'b1});
            if (it == 0) jogada_feita = 1'b1;
            tick();
            jogada_feita = 1'b0;
            chk("to_perde_vida", db_estado, 5'h0D);
            tick();
            chk("to_next", db_estado, (it < 2) ? 5'h02 : 5'h10);
        end
        chk("to_result", {perdeu, timeout, pronto, vidas}, {3'b111, 2'd0});

        // Game 5: fast timeout level.
        nivel_tempo = 1'b1;
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        tick();
        observe_show(1);
        tick();
        chk("fast_entry", db_estado, 5'h06);
        repeat (TOUT / 2 - 1) tick();
        chk("fast_last_cycle", db_estado, 5'h06);
        tick();
        chk("fast_perde_vida", db_estado, 5'h0D);

        // Asynchronous reset while an element is being shown.
        wait_state(5'h03, "rst_in_mostra");
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_async", db_estado, 5'h00);
        tick();
        chk("rst2_state_vidas", {db_estado, vidas}, {5'h00, 2'd3});
        chk("rst2_outputs", {endereco, rodada, ativa_leds_mem, pronto, perdeu}, 11'b0);
        reset_n = 1'b1;
        tick();
        chk("rst2_idle", db_estado, 5'h00);

        // Game 6: record mode.
        nivel_tempo    = 1'b0;
        modo_grava     = 1'b1;
        limite_rodadas = 4'd3;
        iniciar = 1'b1;
        tick();
        chk("g6_prepara", db_estado, 5'h01);
        iniciar = 1'b0;
        observe_show(1);
        do_move(1'b1, 0);
        wait_state(5'h0A, "g6_espera_gravacao");
        chk("g6_wait_outputs", {nova_jogada, vez_jogador, endereco, rodada}, {2'b10, 4'd1, 4'd0});
        jogada_feita = 1'b1;
        tick();
        jogada_feita = 1'b0;
        chk("g6_grava", {db_estado, gravaM, registraR}, {5'h0B, 2'b11});
        gm = 0;
        ms = 0;
        mg = 0;
        c  = 0;
        while (db_estado !== 5'h05 && c < 100) begin
            if (gravaM === 1'b1) gm++;
            if (db_estado === 5'h03) ms++;
            if (db_estado === 5'h0C && ativa_leds_mem === 1'b1) mg++;
            tick();
            c++;
        end
        chk("g6_end_state", db_estado, 5'h05);
        chk("g6_gravaM_pulses", gm, 1);
        chk("g6_no_mostra", ms, 0);
        chk("g6_mostra_grav_cycles", mg, SHOW);
        chk("g6_rodada", rodada, 4'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/unidade_controle_param.md
Name: unidade_controle_param

Overview:
- Parametrised successor to the memory-game control unit: sequencing FSM plus the address/round/timer/lives counters, previously held in the datapath, now owned here.
- Drives the sequence memory address, shows the sequence with internal show/gap timing, and checks player moves against a round limit selected at run time.
- Supports a life count with round replay after an error, and a player-record (grava) mode.
- Sits between the top-level game module and the datapath (sequence RAM, move register, comparator).

Parameters:
- ADDR_W, 4, width of address/round counters; max sequence length 2**ADDR_W
- SHOW_CYC, 500, cycles an element (or feedback) LED stays lit
- GAP_CYC, 250, dark cycles before/between shown elements
- TIMEOUT_CYC, 5000, cycles allowed per move (halved when nivel_tempo=1)
- LIVES, 3, errors tolerated + 1; must be ≥1
- LIVES_W, 2, width of vidas; must hold LIVES

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- iniciar  in  1  start/restart level; honoured only in inicial and terminal states
- jogada_feita  in  1  one-cycle pulse, player pressed a key
- jogada_correta  in  1  datapath compare of registered move vs memory[endereco]
- modo_grava  in  1  1 = player appends next element instead of the FSM advancing round
- nivel_tempo  in  1  1 = timeout TIMEOUT_CYC/2
- limite_rodadas  in  ADDR_W  index of final round (0 = single-element game)
- endereco  out  ADDR_W  sequence memory address
- rodada  out  ADDR_W  current round index
- registraR  out  1  load move register
- gravaM  out  1  write move register to memory[endereco]
- ativa_leds_mem  out  1  LEDs show memory data
- ativa_leds_jog  out  1  LEDs show player move
- vez_jogador  out  1  waiting for a move
- nova_jogada  out  1  waiting for an appended element
- ganhou, perdeu, pronto, timeout  out  1 each  result flags
- vidas  out  LIVES_W  remaining lives
- db_estado  out  5  state code

Behaviour:
- Moore FSM; all outputs decode from registered state/counters. Reset (asynchronous, any state): state inicial, counters 0, vidas=LIVES, all flags 0.
- timer: zeroed on entry to every timed state, increments each cycle while there; tlim = nivel_tempo ? TIMEOUT_CYC/2 : TIMEOUT_CYC.
- States (db_estado code):
  - inicial 00: go to prepara on iniciar.
  - prepara 01: latch limite_rodadas and nivel_tempo; rodada=0, endereco=0, vidas=LIVES; go to inicio_rodada.
  - inicio_rodada 02: endereco=0; after GAP_CYC go to mostra.
  - mostra 03: ativa_leds_mem=1 for SHOW_CYC. Then go to inicio_jogada if endereco==rodada, else go to apaga.
  - apaga 04: after GAP_CYC, endereco++ and go to mostra.
  - inicio_jogada 05: endereco=0, timer=0; go to espera_jogada.
  - espera_jogada 06: vez_jogador=1. If timer==tlim-1, go to perde_vida with timeout_pend=1. Else on jogada_feita go to registra. Timeout has priority over a same-cycle jogada_feita.
  - registra 07: registraR=1; go to compara.
  - compara 08: latch ok=jogada_correta and ultimo=(endereco==rodada); go to feedback.
  - feedback 09: ativa_leds_jog=1 for SHOW_CYC, then branch:
    - !ok: go to perde_vida.
    - ok & !ultimo: endereco++, go to espera_jogada with timer cleared.
    - ok & ultimo & rodada==limite: go to ganhou.
    - ok & ultimo & modo_grava: endereco=rodada+1, go to espera_gravacao.
    - otherwise: rodada++, go to inicio_rodada.
  - espera_gravacao 0A: nova_jogada=1; timeout rule as espera_jogada; on jogada_feita go to grava.
  - grava 0B: registraR=1 and gravaM=1 (datapath writes the registered value one cycle later through a bypass); rodada++, go to mostra_gravacao.
  - mostra_gravacao 0C: ativa_leds_mem=1 for SHOW_CYC, then go to inicio_jogada.
  - perde_vida 0D: vidas--. If vidas==1 before decrement, go to timeout_st if timeout_pend, else perdeu_st. Otherwise clear timeout_pend and go to inicio_rodada to replay the same round.
  - ganhou_st 0E: ganhou=1, pronto=1.
  - perdeu_st 0F: perdeu=1, pronto=1.
  - timeout_st 10: perdeu=1, timeout=1, pronto=1.
  - Terminal states hold until iniciar, then go to prepara.
- Width rules: rodada never exceeds limite, so there is no wrap. limite_rodadas changes mid-game are ignored. jogada_feita outside espera states is ignored.
- Unused encodings go to inicial.

Decomposition:
- Shared package unidade_controle_pkg: state code localparams, plus a width helper function for the timer (clog2 of the max of SHOW_CYC, GAP_CYC, TIMEOUT_CYC).
- One natural sub-module: contador_limite, a zero/enable counter with a done compare. Instantiate it for the timer; address and round stay inline.

Test Plan:
- ADDR_W=4, LIVES=3, limite=2, always-correct moves, short timings: shows 1, 2, 3 elements; endereco sequences 0 / 0,1 / 0,1,2. ganhou=1 and pronto=1 after the 6th move; db_estado=0E.
- limite=2, one wrong move in round 1: vidas goes 3→2, round 1 replayed from endereco 0, then win. Final vidas=2.
- Three wrong moves → perdeu=1, timeout=0, vidas=0. Next iniciar → prepara, vidas=3.
- LIVES=1, no move: timeout=1 exactly TIMEOUT_CYC cycles after entering espera_jogada. With nivel_tempo=1, at TIMEOUT_CYC/2. A same-cycle jogada_feita still yields timeout.
- modo_grava=1, limite=3: after round 0, nova_jogada=1, endereco=1, a single gravaM pulse, rodada=1. No mostra state before the next inicio_jogada.
- reset_n low during mostra: next cycle inicial, all outputs at reset values; iniciar restarts cleanly.
